mutidata: RTL and testbench



---
 rtl/mutidata.sv | 77 +++++++
 tb/tb_mutidata.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mutidata.sv
// Single-clock req/ack 4-phase word transfer. Both handshake directions are
// synchronized, so the source and destination halves can later sit on separate clocks.
module mutidata #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] din,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [DATA_W-1:0] dout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} src_state_t;

  src_state_t        src_state;
  logic [DATA_W-1:0] hold;
  logic              req;
  logic              req_s1, req_s2, req_d;
  logic              ack;
  logic              ack_s1;

  assign in_rdy = (src_state == IDLE);

  // Source side. The state register acts as the second stage of the ack
  // synchronizer: it samples ack_s1 on the edge an ack_s2 flop would load,
  // which gives the rise at T+5 and the return to IDLE at T+10.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      src_state <= IDLE;
      req       <= 1'b0;
      hold      <= '0;
    end else begin
      case (src_state)
        IDLE: if (in_vld) begin
          hold      <= din;
          req       <= 1'b1;
          src_state <= REQ;
        end
        REQ: if (ack_s1) begin
          req       <= 1'b0;
          src_state <= WAIT_LOW;
        end
        WAIT_LOW: if (!ack_s1) src_state <= IDLE;
        default: src_state <= IDLE;
      endcase
    end
  end

  // Destination side: hold is stable while req is high, so it is safe to
  // capture once req has crossed the synchronizer.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_s1  <= 1'b0;
      req_s2  <= 1'b0;
      req_d   <= 1'b0;
      ack     <= 1'b0;
      out_vld <= 1'b0;
      dout    <= '0;
    end else begin
      req_s1  <= req;
      req_s2  <= req_s1;
      req_d   <= req_s2;
      ack     <= req_s2;
      out_vld <= req_s2 & ~req_d;
      if (req_s2 & ~req_d) dout <= hold;
    end
  end

  // Return path, first synchronizer stage.
  always_ff @(posedge clk_i) begin
    if (!rst_i) ack_s1 <= 1'b0;
    else        ack_s1 <= ack;
  end

endmodule

// File: tb/tb_mutidata.sv
// Randomized bench for mutidata: a cycle-level transaction model predicts
// acceptances, in_rdy and delivery timing; a monitor scoreboards out_vld/dout.
module tb_mutidata;
  localparam int DATA_W = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              in_vld;
  logic [DATA_W-1:0] din;
  logic              in_rdy;
  logic              out_vld;
  logic [DATA_W-1:0] dout;

  mutidata #(.DATA_W(DATA_W)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .in_vld (in_vld),
    .din    (din),
    .in_rdy (in_rdy),
    .out_vld(out_vld),
    .dout   (dout)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    int                at_edge;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   rdy_edge = 0;
  int   errors = 0;
  int   checks = 0;
  bit   model_rdy = 1'b1;
  bit   rst_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // One clock edge: apply the transaction rules to the inputs seen at that edge.
  // A word is delivered 3 edges after acceptance; the source is ready again 11 edges later.
  task automatic step(output bit acc);
    @(posedge clk_i);
    cyc++;
    acc = 1'b0;
    if (!rst_i) begin
      q.delete();
      rdy_edge = cyc + 1;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (in_vld && cyc >= rdy_edge) begin
        q.push_back('{at_edge: cyc + 3, data: din});
        rdy_edge = cyc + 11;
        acc = 1'b1;
      end
    end
    model_rdy = (cyc + 1 >= rdy_edge);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_vld = 1'b0;
    repeat (n) step(acc);
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    bit acc;
    in_vld = 1'b1;
    din    = d;
    acc    = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) step(acc);
    check("accept_timeout", {31'd0, acc}, 32'd1);
    in_vld = 1'b0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic [DATA_W-1:0] exp_dout = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (cyc >= 1) begin
        if (rst_seen) begin
          check("rst_out_vld", {31'd0, out_vld}, 32'd0);
          check("rst_dout", {24'd0, dout}, 32'd0);
          check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
          exp_dout = '0;
        end else begin
          check("in_rdy", {31'd0, in_rdy}, {31'd0, model_rdy});
          while (q.size() > 0 && q[0].at_edge < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse cyc=%0d actual=none required=pulse@%0d data=%0h",
                     cyc, e.at_edge, e.data);
          end
          if (out_vld) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_pulse cyc=%0d actual=pulse dout=%0h required=no pulse", cyc, dout);
            end else begin
              e = q.pop_front();
              check("pulse_cycle", cyc, e.at_edge);
              check("pulse_data", {24'd0, dout}, {24'd0, e.data});
              exp_dout = e.data;
            end
          end
          check("dout_hold", {24'd0, dout}, {24'd0, exp_dout});
        end
      end
    end
  end

  initial begin
    bit acc;
    rst_i  = 1'b0;
    in_vld = 1'b1;
    din    = 8'hFF;
    repeat (2) step(acc);
    rst_i  = 1'b1;
    in_vld = 1'b0;
    din    = '0;
    idle(2);

    // single transfer
    send(8'd4);
    idle(12);

    // back-to-back with in_vld held
    send(8'd4);
    send(8'd5);
    send(8'd10);
    idle(12);

    // busy drop: 10 offered while busy must not be captured
    send(8'd5);
    step(acc);
    in_vld = 1'b1;
    din    = 8'd10;
    repeat (7) step(acc);
    in_vld = 1'b0;
    idle(12);

    // reset one edge after acceptance, then a normal transfer
    send(8'h0A);
    rst_i = 1'b0;
    step(acc);
    rst_i = 1'b1;
    send(8'h0B);
    idle(12);

    // data extremes
    send(8'h00);
    idle(12);
    send(8'hFF);
    idle(12);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst_i  = ($urandom_range(0, 99) != 0);
      in_vld = $urandom_range(0, 1);
      din    = DATA_W'($urandom);
      step(acc);
    end
    rst_i = 1'b1;
    idle(15);

    check("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
